alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 8-bit combinational ALU. Takes one operation at a time through a valid/ready input port and returns a registered result through a valid/ready output port.
- Adds Carry and Err flags and variable-amount shifts. Shifts run iteratively, one bit per cycle, or in a single cycle, selected by parameter.
- Sits between the decode/register-read stage and writeback of the processor datapath. Decode stalls on InReady; writeback stalls via OutReady.

---
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one op at a time through valid/ready, registered result
// with Zero/Carry/Err flags. Shifts are either iterative (1 bit/cycle) or barrel.
module alu_seq #(
   parameter int W          = 8,
   parameter bit ITER_SHIFT = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         InValid,
   output logic         InReady,
   input  logic [W-1:0] InputA,
   input  logic [W-1:0] InputB,
   input  logic [3:0]   OP,
   output logic         OutValid,
   input  logic         OutReady,
   output logic [W-1:0] Out,
   output logic         Zero,
   output logic         Carry,
   output logic         Err
);
   localparam int SHW = $clog2(W);

   localparam logic [3:0] OP_LSH = 4'b0000;
   localparam logic [3:0] OP_RSH = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_GEQ = 4'b1000;
   localparam logic [3:0] OP_EQ  = 4'b1001;
   localparam logic [3:0] OP_NEG = 4'b1010;
   localparam logic [3:0] OP_ADD = 4'b1011;
   localparam logic [3:0] OP_NEQ = 4'b1101;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t         state;
   logic [W-1:0]   work;
   logic [SHW-1:0] cnt;
   logic           op_rsh;

   logic [SHW-1:0] shamt;
   logic [2*W-1:0] lsh_full, rsh_full;
   logic [W:0]     sum;
   logic [W-1:0]   res;
   logic           res_c, res_e;
   logic           is_shift, go_exec;
   logic [W-1:0]   step;
   logic           step_c;

   assign shamt = InputB[SHW-1:0];
   // Widened shifts: the bit adjacent to the kept half is the last bit shifted out,
   // and becomes 0 once the shift walks past the operand.
   assign lsh_full = {{W{1'b0}}, InputA} << shamt;
   assign rsh_full = {InputA, {W{1'b0}}} >> shamt;
   assign sum      = {1'b0, InputA} + {1'b0, InputB};
   assign is_shift = (OP == OP_LSH) || (OP == OP_RSH);
   assign go_exec  = ITER_SHIFT && is_shift && (shamt != '0);

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_e = 1'b0;
      case (OP)
         OP_LSH: begin res = lsh_full[W-1:0];     res_c = lsh_full[W];   end
         OP_RSH: begin res = rsh_full[2*W-1:W];   res_c = rsh_full[W-1]; end
         OP_AND: res = InputA & InputB;
         OP_OR:  res = InputA | InputB;
         OP_GEQ: res = {{(W-1){1'b0}}, InputA >= InputB};
         OP_EQ:  res = {{(W-1){1'b0}}, InputA == InputB};
         OP_NEQ: res = {{(W-1){1'b0}}, InputA != InputB};
         OP_NEG: res = ~InputA + W'(1);
         OP_ADD: begin res = sum[W-1:0]; res_c = sum[W]; end
         default: res_e = 1'b1;
      endcase
   end

   assign step   = op_rsh ? (work >> 1) : (work << 1);
   assign step_c = op_rsh ? work[0] : work[W-1];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         InReady  <= 1'b1;
         OutValid <= 1'b0;
         Out      <= '0;
         Zero     <= 1'b0;
         Carry    <= 1'b0;
         Err      <= 1'b0;
         work     <= '0;
         cnt      <= '0;
         op_rsh   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (InValid) begin
               InReady <= 1'b0;
               if (go_exec) begin
                  work   <= InputA;
                  cnt    <= shamt;
                  op_rsh <= OP[0];
                  state  <= EXEC;
               end else begin
                  Out      <= res;
                  Zero     <= (res == '0);
                  Carry    <= res_c;
                  Err      <= res_e;
                  OutValid <= 1'b1;
                  state    <= DONE;
               end
            end
            // Only the final shift-out matters for Carry, so outputs load once at the end.
            EXEC: begin
               work <= step;
               cnt  <= cnt - 1'b1;
               if (cnt == SHW'(1)) begin
                  Out      <= step;
                  Zero     <= (step == '0);
                  Carry    <= step_c;
                  Err      <= 1'b0;
                  OutValid <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: if (OutReady) begin
               OutValid <= 1'b0;
               InReady  <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: W=8 iterative-shift and W=16 barrel-shift instances, directed
// vector table, backpressure/reset sequences, and random ops against a reference model.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst8, rst16, iv8, iv16, ord;
   logic [15:0] a, b;
   logic [3:0]  op;
   logic        ir8, ov8, z8, c8, e8;
   logic        ir16, ov16, z16, c16, e16;
   logic [7:0]  o8;
   logic [15:0] o16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.W(8), .ITER_SHIFT(1)) u8 (
      .Clk(clk), .Reset(rst8), .InValid(iv8), .InReady(ir8),
      .InputA(a[7:0]), .InputB(b[7:0]), .OP(op),
      .OutValid(ov8), .OutReady(ord), .Out(o8),
      .Zero(z8), .Carry(c8), .Err(e8));

   alu_seq #(.W(16), .ITER_SHIFT(0)) u16 (
      .Clk(clk), .Reset(rst16), .InValid(iv16), .InReady(ir16),
      .InputA(a), .InputB(b), .OP(op),
      .OutValid(ov16), .OutReady(ord), .Out(o16),
      .Zero(z16), .Carry(c16), .Err(e16));

   typedef struct {
      bit          sel;
      logic [3:0]  op;
      logic [15:0] a, b, o;
      logic        c, e;
      int          lat;
      string       nm;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: shifts walked bit by bit, everything else plain integer arithmetic.
   function automatic void model(input int w, input bit iter, input logic [3:0] o,
                                 input logic [15:0] aa, input logic [15:0] bb,
                                 output logic [15:0] ro, output logic rc,
                                 output logic re, output int lat);
      int mask, sh, x, av, bv;
      mask = (1 << w) - 1;
      sh   = int'(bb) % ((w == 16) ? 16 : 8);
      av   = int'(aa) & mask;
      bv   = int'(bb) & mask;
      x = 0; rc = 1'b0; re = 1'b0; lat = 1;
      case (o)
         4'd0: begin
            x = av;
            for (int i = 0; i < sh; i++) begin rc = ((x >> (w-1)) & 1) != 0; x = (x << 1) & mask; end
            if (iter && sh != 0) lat = sh + 1;
         end
         4'd1: begin
            x = av;
            for (int i = 0; i < sh; i++) begin rc = (x & 1) != 0; x = x >> 1; end
            if (iter && sh != 0) lat = sh + 1;
         end
         4'd2:  x = av & bv;
         4'd3:  x = av | bv;
         4'd8:  x = (av >= bv) ? 1 : 0;
         4'd9:  x = (av == bv) ? 1 : 0;
         4'd13: x = (av != bv) ? 1 : 0;
         4'd10: x = (-av) & mask;
         4'd11: begin x = av + bv; rc = ((x >> w) & 1) != 0; x = x & mask; end
         default: re = 1'b1;
      endcase
      ro = x[15:0];
   endfunction

   task automatic run(input bit sel, input logic [3:0] o, input logic [15:0] aa,
                      input logic [15:0] bb, output logic [15:0] ro, output logic rc,
                      output logic rz, output logic re, output int lat);
      @(negedge clk);
      chk("in_ready before accept", sel ? ir16 : ir8, 1);
      a = aa; b = bb; op = o; ord = 1'b1;
      if (sel) iv16 = 1'b1; else iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0; iv16 = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      lat = 1;
      while (!(sel ? ov16 : ov8) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ro = sel ? o16 : {8'h00, o8};
      rc = sel ? c16 : c8;
      rz = sel ? z16 : z8;
      re = sel ? e16 : e8;
   endtask

   task automatic do_vec(input bit sel, input logic [3:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [15:0] eo, input logic ec,
                         input logic ee, input int el, input string nm);
      logic [15:0] ro;
      logic        rc, rz, re;
      int          lat;
      run(sel, o, aa, bb, ro, rc, rz, re, lat);
      chk({nm, " out"},     ro,  eo);
      chk({nm, " carry"},   rc,  ec);
      chk({nm, " err"},     re,  ee);
      chk({nm, " zero"},    rz,  (eo == 16'h0));
      chk({nm, " latency"}, lat, el);
   endtask

   initial begin
      vec_t        tv[$];
      logic [15:0] eo, ra, rb;
      logic        ec, ee;
      logic [3:0]  rop;
      int          el, seen;
      bit          s;

      rst8 = 1'b1; rst16 = 1'b1; iv8 = 1'b0; iv16 = 1'b0; ord = 1'b1;
      a = '0; b = '0; op = '0;
      repeat (2) @(negedge clk);
      chk("reset state w8",  {ov8, ir8, z8, c8, e8, 8'h00, o8},   {5'b01000, 16'h0});
      chk("reset state w16", {ov16, ir16, z16, c16, e16, o16},    {5'b01000, 16'h0});
      rst8 = 1'b0; rst16 = 1'b0;

      tv.push_back('{0, 4'b1011, 16'hFF,   16'h01,   16'h00,   1, 0, 1, "add ff+01"});
      tv.push_back('{0, 4'b0000, 16'h81,   16'h03,   16'h08,   0, 0, 4, "lsh 81<<3"});
      tv.push_back('{0, 4'b0001, 16'h81,   16'h01,   16'h40,   1, 0, 2, "rsh 81>>1"});
      tv.push_back('{0, 4'b1000, 16'h03,   16'h04,   16'h00,   0, 0, 1, "geq 3,4"});
      tv.push_back('{0, 4'b1001, 16'h02,   16'h02,   16'h01,   0, 0, 1, "eq 2,2"});
      tv.push_back('{0, 4'b1101, 16'h01,   16'h03,   16'h01,   0, 0, 1, "neq 1,3"});
      tv.push_back('{0, 4'b1010, 16'h01,   16'h00,   16'hFF,   0, 0, 1, "neg 01"});
      tv.push_back('{0, 4'b0011, 16'h01,   16'h00,   16'h01,   0, 0, 1, "or 1,0"});
      tv.push_back('{0, 4'b0010, 16'h01,   16'h01,   16'h01,   0, 0, 1, "and 1,1"});
      tv.push_back('{0, 4'b0100, 16'h5A,   16'h33,   16'h00,   0, 1, 1, "illegal w8"});
      tv.push_back('{0, 4'b0000, 16'h05,   16'h08,   16'h05,   0, 0, 1, "lsh shamt0"});
      tv.push_back('{0, 4'b0001, 16'h80,   16'h07,   16'h01,   0, 0, 8, "rsh 80>>7"});
      tv.push_back('{0, 4'b0000, 16'h01,   16'hF9,   16'h02,   0, 0, 2, "lsh upper b ignored"});
      tv.push_back('{1, 4'b1010, 16'h0001, 16'h0000, 16'hFFFF, 0, 0, 1, "neg w16"});
      tv.push_back('{1, 4'b0000, 16'h8001, 16'h0001, 16'h0002, 1, 0, 1, "lsh w16 barrel"});
      tv.push_back('{1, 4'b0001, 16'h8001, 16'h000F, 16'h0001, 0, 0, 1, "rsh w16 by 15"});
      tv.push_back('{1, 4'b0100, 16'h1234, 16'h0000, 16'h0000, 0, 1, 1, "illegal w16"});
      tv.push_back('{1, 4'b1011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1, 0, 1, "add w16 carry"});
      foreach (tv[i])
         do_vec(tv[i].sel, tv[i].op, tv[i].a, tv[i].b, tv[i].o, tv[i].c, tv[i].e, tv[i].lat, tv[i].nm);

      // Backpressure: result must stay frozen while inputs churn.
      @(negedge clk);
      a = 16'h10; b = 16'h20; op = 4'b1011; ord = 1'b0; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      el = 0;
      while (!ov8 && el < 10) begin @(negedge clk); el++; end
      chk("bp valid", ov8, 1);
      for (int i = 0; i < 10; i++) begin
         chk("bp hold", {ov8, ir8, z8, c8, e8, o8}, {5'b10000, 8'h30});
         iv8 = 1'($urandom); a = 16'($urandom); op = 4'($urandom);
         @(negedge clk);
      end
      iv8 = 1'b0; ord = 1'b1;
      @(negedge clk);
      chk("bp release", {ov8, ir8}, 2'b01);

      // Reset in the third EXEC cycle of a 7-bit shift.
      a = 16'h01; b = 16'h07; op = 4'b0000; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      chk("reset mid-exec", {ov8, ir8, z8, c8, e8, o8}, {5'b01000, 8'h00});
      rst8 = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (ov8) seen++; end
      chk("no result after reset", seen, 0);

      for (int n = 0; n < 300; n++) begin
         s   = 1'($urandom);
         rop = 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (!s) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
         model(s ? 16 : 8, !s, rop, ra, rb, eo, ec, ee, el);
         do_vec(s, rop, ra, rb, eo, ec, ee, el, $sformatf("rand%0d op%0h", n, rop));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
